// File: rtl/reset_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : reset_sequencer                                                |
// | Brief   : Staged reset release after PLL lock, with 4-phase soft reset.  |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module reset_sequencer #(
   parameter int NSTAGE    = 4,
   parameter int LOCK_DLY  = 16,
   parameter int STAGE_DLY = 4,
   parameter int SOFT_LEN  = 8,
   parameter int CW        = 8
) (
   input  logic              clock,
   input  logic              locked,
   input  logic              hold,
   input  logic              soft_req,
   output logic              soft_ack,
   output logic [NSTAGE-1:0] rst_out,
   output logic              ready,
   output logic [1:0]        state
);

   localparam int IW = (NSTAGE > 1) ? $clog2(NSTAGE) : 1;

   localparam logic [1:0] ST_STABLE  = 2'd0;
   localparam logic [1:0] ST_RELEASE = 2'd1;
   localparam logic [1:0] ST_RUN     = 2'd2;
   localparam logic [1:0] ST_SOFT    = 2'd3;

   localparam logic [CW-1:0] LOCK_LIM  = CW'(LOCK_DLY - 1);
   localparam logic [CW-1:0] STAGE_LIM = CW'(STAGE_DLY - 1);
   localparam logic [CW-1:0] SOFT_LIM  = CW'(SOFT_LEN - 1);
   localparam logic [IW-1:0] IDX_LAST  = IW'(NSTAGE - 1);

   logic [1:0]        state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic              soft_seq_q, soft_seq_d;
   logic [NSTAGE-1:0] rst_q, rst_d;
   logic              ready_q, ready_d;
   logic              ack_q, ack_d;

   logic              w_stage_done;
   logic              w_last_stage;
   logic              w_soft_start;

   assign w_stage_done = (state_q == ST_RELEASE) && !hold && (cnt_q == STAGE_LIM);
   assign w_last_stage = w_stage_done && (idx_q == IDX_LAST);
   // An outstanding acknowledge blocks a new request until soft_req has dropped.
   assign w_soft_start = (state_q == ST_RUN) && soft_req && !ack_q;

   always_ff @(posedge clock or negedge locked) begin
      if (!locked) begin
         state_q    <= ST_STABLE;
         cnt_q      <= '0;
         idx_q      <= '0;
         soft_seq_q <= 1'b0;
         rst_q      <= '1;
         ready_q    <= 1'b0;
         ack_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         soft_seq_q <= soft_seq_d;
         rst_q      <= rst_d;
         ready_q    <= ready_d;
         ack_q      <= ack_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      soft_seq_d = soft_seq_q;
      case (state_q)
         ST_STABLE: begin
            if (!hold) begin
               if (cnt_q == LOCK_LIM) begin
                  state_d = ST_RELEASE;
                  cnt_d   = '0;
                  idx_d   = '0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         ST_RELEASE: begin
            if (!hold) begin
               if (cnt_q == STAGE_LIM) begin
                  cnt_d = '0;
                  if (idx_q == IDX_LAST) begin
                     state_d    = ST_RUN;
                     idx_d      = '0;
                     soft_seq_d = 1'b0;
                  end else begin
                     idx_d = idx_q + IW'(1);
                  end
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         ST_RUN: begin
            if (w_soft_start) begin
               state_d    = ST_SOFT;
               cnt_d      = '0;
               idx_d      = '0;
               soft_seq_d = 1'b1;
            end
         end
         ST_SOFT: begin
            if (!hold) begin
               if (cnt_q == SOFT_LIM) begin
                  state_d = ST_RELEASE;
                  cnt_d   = '0;
                  idx_d   = '0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         default: begin
            state_d = ST_STABLE;
            cnt_d   = '0;
            idx_d   = '0;
         end
      endcase
   end

   always_comb begin
      rst_d = rst_q;
      ack_d = ack_q;
      if (ack_q && !soft_req) begin
         ack_d = 1'b0;
      end
      if (state_q == ST_STABLE || state_q == ST_SOFT) begin
         rst_d = '1;
      end
      if (w_stage_done) begin
         rst_d[idx_q] = 1'b0;
      end
      if (w_last_stage && soft_seq_q) begin
         ack_d = 1'b1;
      end
      if (w_soft_start) begin
         rst_d = '1;
      end
      ready_d = (state_d == ST_RUN);
   end

   assign rst_out  = rst_q;
   assign ready    = ready_q;
   assign soft_ack = ack_q;
   assign state    = state_q;

endmodule
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_reset_sequencer                                             |
// | Brief   : Self-checking bench for reset_sequencer (table + scoreboard).  |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_reset_sequencer;

   localparam int NS   = 4;
   localparam int LOCK = 16;
   localparam int STG  = 4;
   localparam int SL   = 8;

   logic          clock    = 1'b0;
   logic          locked   = 1'b1;
   logic          hold     = 1'b0;
   logic          soft_req = 1'b0;
   logic          soft_ack;
   logic [NS-1:0] rst_out;
   logic          ready;
   logic [1:0]    state;

   reset_sequencer #(
      .NSTAGE   (NS),
      .LOCK_DLY (LOCK),
      .STAGE_DLY(STG),
      .SOFT_LEN (SL),
      .CW       (8)
   ) dut (
      .clock   (clock),
      .locked  (locked),
      .hold    (hold),
      .soft_req(soft_req),
      .soft_ack(soft_ack),
      .rst_out (rst_out),
      .ready   (ready),
      .state   (state)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [NS-1:0] rst;
      logic          rdy;
      logic          ack;
      logic [1:0]    st;
   } exp_t;

   typedef struct {
      int   edge_n;
      logic h;
      logic sr;
      exp_t e;
   } vec_t;

   exp_t sbq[$];
   int   errors = 0;
   int   checks = 0;
   vec_t vt[12];

   function automatic exp_t mk(input logic [NS-1:0] r, input logic rd, input logic ak,
                               input logic [1:0] st);
      mk = {r, rd, ak, st};
   endfunction

   // Expected outputs k edges after lock with no soft activity.
   function automatic exp_t pu_exp(input int k);
      exp_t e;
      e.ack = 1'b0;
      e.rdy = (k >= LOCK + NS * STG);
      e.st  = (k < LOCK) ? 2'd0 : ((k < LOCK + NS * STG) ? 2'd1 : 2'd2);
      for (int i = 0; i < NS; i++) e.rst[i] = (k < LOCK + (i + 1) * STG);
      return e;
   endfunction

   // Expected outputs j edges after the edge that accepted a soft request.
   function automatic exp_t soft_exp(input int j, input logic ack);
      exp_t e;
      e.ack = ack;
      e.rdy = (j >= SL + NS * STG);
      e.st  = (j < SL) ? 2'd3 : ((j < SL + NS * STG) ? 2'd1 : 2'd2);
      for (int i = 0; i < NS; i++) e.rst[i] = (j < SL + (i + 1) * STG);
      return e;
   endfunction

   task automatic compare(input string tag, input int n);
      exp_t e;
      exp_t a;
      a = {rst_out, ready, soft_ack, state};
      checks++;
      if (sbq.size() == 0) begin
         errors++;
         $display("FAIL %s edge %0d: scoreboard empty, got rst=%b ready=%b ack=%b state=%0d",
                  tag, n, a.rst, a.rdy, a.ack, a.st);
      end else begin
         e = sbq.pop_front();
         if (a !== e) begin
            errors++;
            $display("FAIL %s edge %0d: got rst=%b ready=%b ack=%b state=%0d, expected rst=%b ready=%b ack=%b state=%0d",
                     tag, n, a.rst, a.rdy, a.ack, a.st, e.rst, e.rdy, e.ack, e.st);
         end
      end
   endtask

   task automatic tick(input string tag, input int n, input logic h, input logic sr,
                       input exp_t e);
      hold     = h;
      soft_req = sr;
      sbq.push_back(e);
      @(posedge clock);
      #1;
      compare(tag, n);
   endtask

   task automatic step(input logic h, input logic sr);
      hold     = h;
      soft_req = sr;
      @(posedge clock);
      #1;
   endtask

   task automatic check_now(input string tag, input int n, input exp_t e);
      sbq.push_back(e);
      compare(tag, n);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

   initial begin
      int edge_n;

      vt[0]  = '{1,  1'b0, 1'b0, mk(4'b1111, 1'b0, 1'b0, 2'd0)};
      vt[1]  = '{15, 1'b0, 1'b0, mk(4'b1111, 1'b0, 1'b0, 2'd0)};
      vt[2]  = '{16, 1'b0, 1'b0, mk(4'b1111, 1'b0, 1'b0, 2'd1)};
      vt[3]  = '{19, 1'b0, 1'b0, mk(4'b1111, 1'b0, 1'b0, 2'd1)};
      vt[4]  = '{20, 1'b0, 1'b0, mk(4'b1110, 1'b0, 1'b0, 2'd1)};
      vt[5]  = '{23, 1'b0, 1'b0, mk(4'b1110, 1'b0, 1'b0, 2'd1)};
      vt[6]  = '{24, 1'b0, 1'b0, mk(4'b1100, 1'b0, 1'b0, 2'd1)};
      vt[7]  = '{27, 1'b0, 1'b0, mk(4'b1100, 1'b0, 1'b0, 2'd1)};
      vt[8]  = '{28, 1'b0, 1'b0, mk(4'b1000, 1'b0, 1'b0, 2'd1)};
      vt[9]  = '{31, 1'b0, 1'b0, mk(4'b1000, 1'b0, 1'b0, 2'd1)};
      vt[10] = '{32, 1'b0, 1'b0, mk(4'b0000, 1'b1, 1'b0, 2'd2)};
      vt[11] = '{34, 1'b0, 1'b0, mk(4'b0000, 1'b1, 1'b0, 2'd2)};

      // Reset state while lock is low
      #1 locked = 1'b0;
      #1 check_now("reset_async", 0, mk(4'b1111, 1'b0, 1'b0, 2'd0));
      for (int k = 0; k < 3; k++) tick("reset_held", k, 1'b0, 1'b0, mk(4'b1111, 1'b0, 1'b0, 2'd0));

      // Power-up release, table-driven
      locked = 1'b1;
      edge_n = 0;
      for (int v = 0; v < 12; v++) begin
         while (edge_n < vt[v].edge_n - 1) begin
            step(vt[v].h, vt[v].sr);
            edge_n++;
         end
         tick("powerup", vt[v].edge_n, vt[v].h, vt[v].sr, vt[v].e);
         edge_n++;
      end

      // Lock loss in RUN, then hold for 5 cycles from edge 10
      locked = 1'b0;
      #1 check_now("lockloss_run", 0, pu_exp(0));
      @(posedge clock);
      #1 locked = 1'b1;
      for (int k = 1; k <= 40; k++)
         tick("hold", k, (k >= 10 && k <= 14), 1'b0,
              pu_exp(k < 10 ? k : (k <= 14 ? 9 : k - 5)));

      // Lock loss mid-RELEASE, then full replay
      locked = 1'b0;
      #1;
      @(posedge clock);
      #1 locked = 1'b1;
      for (int k = 1; k <= 25; k++) tick("relock", k, 1'b0, 1'b0, pu_exp(k));
      #3 locked = 1'b0;
      #1 check_now("lockloss_release", 25, pu_exp(0));
      tick("lockloss_low", 26, 1'b0, 1'b0, pu_exp(0));
      locked = 1'b1;
      for (int k = 1; k <= 33; k++) tick("replay", k, 1'b0, 1'b0, pu_exp(k));

      // Soft reset from RUN, held request must not retrigger while acknowledged
      for (int j = 0; j <= 26; j++) tick("soft", j, 1'b0, 1'b1, soft_exp(j, (j >= 24)));
      tick("soft_ackdrop", 27, 1'b0, 1'b0, soft_exp(24, 1'b0));
      tick("soft2_entry", 0, 1'b1, 1'b1, soft_exp(0, 1'b0));
      for (int j = 1; j <= 24; j++) tick("soft2", j, 1'b0, 1'b1, soft_exp(j, (j >= 24)));
      tick("soft2_ackdrop", 25, 1'b0, 1'b0, soft_exp(24, 1'b0));

      // Request held high through power-up is only seen once RUN is reached
      locked = 1'b0;
      #1;
      @(posedge clock);
      #1;
      soft_req = 1'b1;
      locked   = 1'b1;
      for (int k = 1; k <= 32; k++) tick("softpu", k, 1'b0, 1'b1, pu_exp(k));
      for (int j = 0; j <= 24; j++) tick("softpu_soft", 33 + j, 1'b0, 1'b1, soft_exp(j, (j >= 24)));
      tick("softpu_ackdrop", 58, 1'b0, 1'b0, soft_exp(24, 1'b0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
